// File: rtl/perf_pkg.sv
// Shared types for the performance monitor: event selects, channel FSM states
// and the index-width helper used for channel select ports.
package perf_pkg;

  localparam int SEL_W = 2;

  typedef enum logic [SEL_W-1:0] {
    CYCLES     = 2'd0,
    PC_CHANGE  = 2'd1,
    MEM_WRITE  = 2'd2,
    START_HITS = 2'd3
  } event_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_channel.sv
// One monitor channel: start/stop-PC armed FSM, saturating event counter and
// its configuration registers. Exposes next-state count for the readback mux.
module perf_channel
  import perf_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int PC_WIDTH    = 10,
  parameter int FINAL_PC    = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   pc_changed,
  input  logic                   write_m,
  input  logic                   cfg_load,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic [PC_WIDTH-1:0]    cfg_start_pc,
  input  logic [PC_WIDTH-1:0]    cfg_stop_pc,
  output logic [COUNT_WIDTH-1:0] count_next,
  output logic                   ovf_next,
  output logic                   done,
  output logic                   running
);

  ch_state_e               state_q, state_d;
  event_sel_e              sel_q;
  logic [PC_WIDTH-1:0]     start_pc_q, stop_pc_q;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    start_hit, stop_hit, ev, cnt_en;

  assign start_hit = (pc == start_pc_q);
  assign stop_hit  = (pc == stop_pc_q);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    ev      = 1'b0;
    cnt_en  = 1'b0;
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    case (sel_q)
      CYCLES:     ev = 1'b1;
      PC_CHANGE:  ev = pc_changed;
      MEM_WRITE:  ev = write_m;
      START_HITS: ev = start_hit;
      default:    ev = 1'b0;
    endcase

    if (cfg_load) begin
      state_d = IDLE;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en) begin
      case (state_q)
        IDLE: if (start_hit) begin
          state_d = RUN;
          cnt_en  = 1'b1;
        end
        RUN: begin
          cnt_en = 1'b1;
          if (stop_hit) state_d = DONE;
        end
        default: ;
      endcase

      if (cnt_en && ev) begin
        if (&count_q) ovf_d = 1'b1;
        else          count_d = count_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      sel_q      <= CYCLES;
      start_pc_q <= '0;
      stop_pc_q  <= PC_WIDTH'(FINAL_PC);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (cfg_load) begin
        sel_q      <= event_sel_e'(cfg_sel);
        start_pc_q <= cfg_start_pc;
        stop_pc_q  <= cfg_stop_pc;
      end
    end
  end

  assign count_next = count_d;
  assign ovf_next   = ovf_d;
  assign done       = (state_q == DONE);
  assign running    = (state_q == RUN);

endmodule

// File: rtl/perf_monitor.sv
// Multi-channel performance monitor beside the CPU: tracks previous PC, the
// sticky finished flag, config decode and the registered readback mux.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int COUNT_WIDTH  = 32,
  parameter int PC_WIDTH     = 10,
  parameter int FINAL_PC     = 1023,
  localparam int CH_W        = idx_width(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic                    write_m,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [SEL_W-1:0]        cfg_sel,
  input  logic [PC_WIDTH-1:0]     cfg_start_pc,
  input  logic [PC_WIDTH-1:0]     cfg_stop_pc,
  input  logic [CH_W-1:0]         rd_ch,
  output logic [COUNT_WIDTH-1:0]  rd_count,
  output logic                    rd_ovf,
  output logic [NUM_CHANNELS-1:0] ch_done,
  output logic [NUM_CHANNELS-1:0] ch_running,
  output logic                    finished
);

  logic [PC_WIDTH-1:0]    prev_pc;
  logic                   pc_changed;
  logic [COUNT_WIDTH-1:0] cnt_next [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ovf_next;
  logic [COUNT_WIDTH-1:0] rd_count_d;
  logic                   rd_ovf_d;

  assign pc_changed = (pc != prev_pc);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    perf_channel #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .PC_WIDTH    (PC_WIDTH),
      .FINAL_PC    (FINAL_PC)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .en           (!finished),
      .pc           (pc),
      .pc_changed   (pc_changed),
      .write_m      (write_m),
      .cfg_load     (cfg_we && (cfg_ch == CH_W'(g))),
      .cfg_sel      (cfg_sel),
      .cfg_start_pc (cfg_start_pc),
      .cfg_stop_pc  (cfg_stop_pc),
      .count_next   (cnt_next[g]),
      .ovf_next     (ovf_next[g]),
      .done         (ch_done[g]),
      .running      (ch_running[g])
    );
  end

  // Readback samples the post-update value; unmatched selects read zero.
  always_comb begin
    rd_count_d = '0;
    rd_ovf_d   = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_count_d = cnt_next[i];
        rd_ovf_d   = ovf_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc  <= '0;
      finished <= 1'b0;
      rd_count <= '0;
      rd_ovf   <= 1'b0;
    end else begin
      prev_pc  <= pc;
      rd_count <= rd_count_d;
      rd_ovf   <= rd_ovf_d;
      if (pc == PC_WIDTH'(FINAL_PC)) finished <= 1'b1;
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a default 4x32 instance plus a 3x4 instance
// for saturation and out-of-range readback, both on shared stimulus.
module tb_perf_monitor;
  import perf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pc;
  logic        write_m;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_sel;
  logic [9:0]  cfg_start_pc;
  logic [9:0]  cfg_stop_pc;
  logic [1:0]  rd_ch;

  logic [31:0] rd_count;
  logic        rd_ovf;
  logic [3:0]  ch_done, ch_running;
  logic        finished;

  logic [3:0]  s_rd_count;
  logic        s_rd_ovf;
  logic [2:0]  s_ch_done, s_ch_running;
  logic        s_finished;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  perf_monitor u_dut (
    .clk (clk), .reset (reset), .pc (pc), .write_m (write_m),
    .cfg_we (cfg_we), .cfg_ch (cfg_ch), .cfg_sel (cfg_sel),
    .cfg_start_pc (cfg_start_pc), .cfg_stop_pc (cfg_stop_pc),
    .rd_ch (rd_ch), .rd_count (rd_count), .rd_ovf (rd_ovf),
    .ch_done (ch_done), .ch_running (ch_running), .finished (finished)
  );

  perf_monitor #(.NUM_CHANNELS(3), .COUNT_WIDTH(4)) u_small (
    .clk (clk), .reset (reset), .pc (pc), .write_m (write_m),
    .cfg_we (cfg_we), .cfg_ch (cfg_ch), .cfg_sel (cfg_sel),
    .cfg_start_pc (cfg_start_pc), .cfg_stop_pc (cfg_stop_pc),
    .rd_ch (rd_ch), .rd_count (s_rd_count), .rd_ovf (s_rd_ovf),
    .ch_done (s_ch_done), .ch_running (s_ch_running), .finished (s_finished)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    pc      = '0;
    write_m = 1'b0;
    cfg_we  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input event_sel_e sel,
                     input logic [9:0] start_pc, input logic [9:0] stop_pc);
    cfg_we       = 1'b1;
    cfg_ch       = ch;
    cfg_sel      = sel;
    cfg_start_pc = start_pc;
    cfg_stop_pc  = stop_pc;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    cfg_ch = '0; cfg_sel = '0; cfg_start_pc = '0; cfg_stop_pc = '0; rd_ch = '0;

    // Reset state
    do_reset();
    check("rst_rd_count", rd_count, 0);
    check("rst_rd_ovf", {31'd0, rd_ovf}, 0);
    check("rst_ch_done", {28'd0, ch_done}, 0);
    check("rst_ch_running", {28'd0, ch_running}, 0);
    check("rst_finished", {31'd0, finished}, 0);

    // CYCLES between pc 5 and 9 inclusive
    cfg(2'd0, CYCLES, 10'd5, 10'd9);
    for (int p = 0; p <= 12; p++) begin
      pc = 10'(p);
      tick();
    end
    check("cyc_count", rd_count, 5);
    check("cyc_done", {31'd0, ch_done[0]}, 1);
    check("cyc_running", {31'd0, ch_running[0]}, 0);

    // PC_CHANGE: arm at pc 0, then changes 0->3, 3->4, 4->5
    do_reset();
    cfg(2'd1, PC_CHANGE, 10'd0, 10'd1023);
    rd_ch = 2'd1;
    pc = 10'd0;
    tick();
    check("pcchg_armed", rd_count, 0);
    pc = 10'd3;
    tick();
    check("pcchg_first", rd_count, 1);
    repeat (3) tick();
    pc = 10'd4; tick();
    pc = 10'd5; tick();
    check("pcchg_count", rd_count, 3);
    check("pcchg_running", {31'd0, ch_running[1]}, 1);

    // MEM_WRITE with start == stop: one iteration
    cfg(2'd2, MEM_WRITE, 10'd2, 10'd2);
    rd_ch   = 2'd2;
    write_m = 1'b1;
    pc = 10'd2; tick();
    check("memw_arm_count", rd_count, 1);
    check("memw_arm_running", {31'd0, ch_running[2]}, 1);
    pc = 10'd3; tick();
    pc = 10'd2; tick();
    check("memw_count", rd_count, 3);
    check("memw_done", {31'd0, ch_done[2]}, 1);
    pc = 10'd2; tick();
    check("memw_done_hold", rd_count, 3);
    write_m = 1'b0;

    // START_HITS, plus out-of-range readback on the 3-channel instance
    cfg(2'd3, START_HITS, 10'd7, 10'd1023);
    rd_ch = 2'd3;
    pc = 10'd7; tick();
    pc = 10'd8; tick();
    pc = 10'd7; tick();
    pc = 10'd7; tick();
    pc = 10'd9; tick();
    check("hits_count", rd_count, 3);
    check("small_oob_rd", {28'd0, s_rd_count}, 0);

    // Saturation: 20 cycles on a 4-bit counter
    do_reset();
    rd_ch = 2'd0;
    cfg(2'd0, CYCLES, 10'd0, 10'd500);
    repeat (20) tick();
    check("sat_small_count", {28'd0, s_rd_count}, 15);
    check("sat_small_ovf", {31'd0, s_rd_ovf}, 1);
    check("sat_wide_count", rd_count, 20);
    check("sat_wide_ovf", {31'd0, rd_ovf}, 0);
    cfg(2'd0, CYCLES, 10'd0, 10'd500);
    check("sat_clr_count", {28'd0, s_rd_count}, 0);
    check("sat_clr_ovf", {31'd0, s_rd_ovf}, 0);
    check("sat_clr_running", {31'd0, s_ch_running[0]}, 0);

    // finished: FINAL_PC cycle counted, then everything frozen
    repeat (3) tick();
    check("fin_pre_count", rd_count, 3);
    pc = 10'd1023; tick();
    check("fin_final_count", rd_count, 4);
    check("fin_set", {31'd0, finished}, 1);
    check("fin_small_set", {31'd0, s_finished}, 1);
    write_m = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc = 10'(i * 100);
      tick();
    end
    write_m = 1'b0;
    check("fin_frozen_count", rd_count, 4);
    check("fin_frozen_running", {28'd0, ch_running}, 32'h1);
    check("fin_frozen_done", {28'd0, ch_done}, 32'he);
    check("fin_small_running", {29'd0, s_ch_running}, 32'h1);
    check("fin_small_done", {29'd0, s_ch_done}, 32'h6);
    check("fin_sticky", {31'd0, finished}, 1);
    cfg(2'd0, CYCLES, 10'd0, 10'd500);
    check("fin_cfg_count", rd_count, 0);
    check("fin_cfg_running", {31'd0, ch_running[0]}, 0);
    pc = 10'd0; tick();
    check("fin_cfg_no_arm", {31'd0, ch_running[0]}, 0);
    check("fin_cfg_still", {31'd0, finished}, 1);

    // Config write beats the stop-PC match in the same cycle
    do_reset();
    rd_ch = 2'd0;
    cfg(2'd0, CYCLES, 10'd5, 10'd9);
    for (int p = 5; p <= 8; p++) begin
      pc = 10'(p);
      tick();
    end
    check("prio_pre_count", rd_count, 4);
    pc = 10'd9;
    cfg(2'd0, CYCLES, 10'd5, 10'd9);
    check("prio_not_done", {31'd0, ch_done[0]}, 0);
    check("prio_idle", {31'd0, ch_running[0]}, 0);
    check("prio_count", rd_count, 0);
    pc = 10'd10; tick();
    check("prio_count_later", rd_count, 0);
    check("prio_done_later", {31'd0, ch_done[0]}, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
Name: perf_monitor

Overview:
- Multi-channel performance monitor; parametrised successor of the single cycle-to-FINAL_PC perf counter.
- Each channel is armed by a start PC and stopped by a stop PC, and counts a selectable event.
- Drives the `finished` clock-gate request to the CPU clock control.
- Sits beside the CPU on the CPU clock. It observes the PC and data-memory write strobe only; it never stalls the core.

Parameters:
- NUM_CHANNELS, 4, number of independent counter channels (1..16).
- COUNT_WIDTH, 32, counter width per channel; counters saturate.
- PC_WIDTH, 10, width of observed instruction address.
- FINAL_PC, 1023, PC value that ends the run and sets `finished`.

Ports:
- clk  in  1  CPU clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  PC_WIDTH  current instruction address from the CPU.
- write_m  in  1  data-memory write strobe from the CPU.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  $clog2(NUM_CHANNELS) (min 1)  channel being configured.
- cfg_sel  in  2  event select: 0=CYCLES, 1=PC_CHANGE, 2=MEM_WRITE, 3=START_HITS.
- cfg_start_pc  in  PC_WIDTH  arm PC.
- cfg_stop_pc  in  PC_WIDTH  stop PC.
- rd_ch  in  $clog2(NUM_CHANNELS) (min 1)  readback channel select.
- rd_count  out  COUNT_WIDTH  count of rd_ch, registered.
- rd_ovf  out  1  saturation flag of rd_ch, registered.
- ch_done  out  NUM_CHANNELS  per-channel DONE state.
- ch_running  out  NUM_CHANNELS  per-channel RUN state.
- finished  out  1  sticky; set after FINAL_PC is reached.

Behaviour:
- Reset, synchronous and active-high, sets all of the following:
  - Every channel: state IDLE, count 0, ovf 0, sel CYCLES, start_pc 0, stop_pc FINAL_PC.
  - finished=0, rd_count=0, rd_ovf=0, prev_pc=0.
  - ch_done and ch_running are 0.
- Event qualifiers, evaluated in the current cycle:
  - CYCLES: always 1.
  - PC_CHANGE: pc != prev_pc, where prev_pc is the registered pc of the previous cycle.
  - MEM_WRITE: write_m.
  - START_HITS: pc == start_pc.
- Count enable is `!finished`. While finished=1, no channel changes count or state except through a config write.
- Per-channel FSM:
  - IDLE: if pc==start_pc → RUN. The event in this matching cycle IS counted.
  - RUN: count += event. If pc==stop_pc → DONE, and the event in this cycle IS counted.
  - DONE: hold count; terminal until a config write or reset.
  - If start_pc==stop_pc, the channel enters RUN on the first match and goes to DONE on the next match. This measures one iteration.
- Saturation:
  - If count is all-ones and the event is 1, count holds and ovf←1.
  - ovf is sticky until a config write or reset.
- Config write (cfg_we=1):
  - Channel cfg_ch loads sel, start_pc and stop_pc; count←0, ovf←0, state←IDLE, next cycle.
  - It has priority over any event or transition on that channel in the same cycle.
  - Other channels are unaffected.
  - It does not clear `finished`.
- finished:
  - Set to 1 the cycle after pc==FINAL_PC is sampled. Sticky until reset.
  - The FINAL_PC cycle itself is still counted.
- Readback:
  - rd_count and rd_ovf are registered, with 1-cycle latency from rd_ch.
  - They reflect channel state after the current edge's update.
  - An out-of-range rd_ch reads 0.
- ch_done and ch_running are combinational decodes of the state registers.

Decomposition:
- Package `perf_pkg`:
  - `event_sel_e` (CYCLES, PC_CHANGE, MEM_WRITE, START_HITS).
  - `ch_state_e` (IDLE, RUN, DONE).
  - Width constant for cfg_sel.
- Sub-module `perf_channel`:
  - One FSM, counter, saturation logic and config registers.
  - Instantiated NUM_CHANNELS times by generate.
- The top level holds prev_pc, the finished flag, the config decode and the readback mux.

Test Plan:
- Reset, then cfg ch0 {CYCLES, start=5, stop=9}. Drive pc 0,1,…,12, one step per cycle → ch0 count=5 (pc 5..9), ch_done[0]=1, ch_running[0]=0.
- Cfg ch1 {PC_CHANGE, start=0, stop=FINAL_PC}. Hold pc=3 for 4 cycles, then step 4,5 → count increments only on the 3→4 and 4→5 changes, plus the first-cycle change from prev_pc=0 → count=3.
- Cfg ch2 {MEM_WRITE, start=2, stop=2}. pc sequence 2,3,2 with write_m=1 on all three cycles → RUN at the first pc=2, DONE at the second pc=2, count=3.
- Set COUNT_WIDTH=4. Run CYCLES for 20 cycles in RUN → count=15, rd_ovf=1. A config write to that channel → count=0, ovf=0.
- Drive pc=FINAL_PC (1023) → finished=1 the next cycle. A further 10 cycles produce no count changes on any channel. A config write still clears the targeted channel.
- Issue cfg_we to ch0 in the same cycle as its stop-PC match → ch0 is IDLE with count 0, not DONE. Set rd_ch=0 → rd_count=0 one cycle later.
